m_trap_sequencer: RTL
=====================

// Module: m_trap_sequencer
// PURPOSE
//   Drives the machine-CSR file's trap inputs. Arbitrates raw exceptions from
//   fetch/decode and execute/memory plus mret, presents one registered event to
//   the CSR file, flushes the pipeline, then redirects the PC to the handler
//   base or to the return address, using mtvec and mepc read back from the CSR file.
// PARAMETERS
//   XLEN          `XLEN_64b  data width = 1<<(XLEN+4) (W below)
//   FLUSH_CYCLES  3          cycles o_flush is held (1..15)
//   NO_E          `NO_E      4-bit "no exception" code
// PORTS
//   i_clk                   in   1   clock
//   i_rst                   in   1   reset, synchronous, active-high
//   i_clk_en                in   1   global clock enable; low = full freeze
//   i_exc_code_f_d          in   4   raw fetch/decode exception code
//   i_exc_pc_f_d            in   W   PC of faulting fetch/decode instr
//   i_exc_code_e_m          in   4   raw execute/memory exception code
//   i_exc_pc_e_m            in   W   PC of faulting exec/mem instr
//   i_exc_addr_e_m          in   W   faulting data address (for mtval)
//   i_mret                  in   1   mret in execute stage
//   i_mtvec                 in   W   mtvec from CSR file
//   i_mepc                  in   W   mepc from CSR file
//   o_exception_code_f_d_ff out  4   registered f/d code to CSR file
//   o_exception_pc_f_d_ff   out  W   registered f/d PC to CSR file
//   o_exception_code_e_m_ff out  4   registered e/m code to CSR file
//   o_exception_pc_e_m_ff   out  W   registered e/m PC to CSR file
//   o_exception_addr_e_m_ff out  W   registered e/m addr to CSR file
//   o_mret_e                out  1   registered mret pulse to CSR file
//   o_flush                 out  1   kill all in-flight pipeline stages
//   o_stall_fetch           out  1   hold fetch while not IDLE
//   o_redirect_valid        out  1   1-cycle pulse: load o_redirect_pc
//   o_redirect_pc           out  W   new PC
//   o_busy                  out  1   state != IDLE
// BEHAVIOUR
//   States: IDLE, CAPTURE, FLUSH, REDIRECT. Transitions only when i_clk_en=1.
//   Reset: state=IDLE; both *_code_*_ff=NO_E; all PCs/addr=0; o_mret_e,
//     o_flush, o_stall_fetch, o_redirect_valid, o_busy=0; flush counter=0.
//   IDLE, event accepted with priority: e_m exception > f_d exception > mret
//     (e_m is the older instruction). Exactly one event is presented; the
//     other *_code_ff stays NO_E, so the CSR file never sees two at once.
//   IDLE->CAPTURE: *_ff regs of the winning event load for exactly one cycle
//     (one-cycle CSR write window); o_mret_e=1 for that cycle if mret won.
//   CAPTURE->FLUSH: all *_ff codes back to NO_E, o_mret_e=0; o_flush=1 for
//     FLUSH_CYCLES cycles (counter FLUSH_CYCLES-1 down to 0).
//   FLUSH->REDIRECT when counter==0. Target sampled in REDIRECT (CSR updated):
//     trap: {i_mtvec[W-1:2],2'b00} for both mtvec modes (sync exceptions
//     never vector); mret: {i_mepc[W-1:1],1'b0}.
//   REDIRECT->IDLE: o_redirect_valid=1 that cycle only.
//   Latency: event seen in IDLE at cycle N -> ff outputs cycle N+1, flush
//     N+2..N+1+FLUSH_CYCLES, redirect pulse N+2+FLUSH_CYCLES.
//   o_stall_fetch = o_busy = (state!=IDLE).
//   Events arriving outside IDLE are ignored (wrong-path, being flushed).
//   i_clk_en=0 in any state: all regs and counter hold; outputs unchanged.
//   i_rst mid-sequence: abort to IDLE next edge, no redirect, codes=NO_E.
//   Exception and mret on the same cycle: exception wins, mret dropped.
// TESTING
//   f_d code 2, pc 0x100, mtvec 0x8000_0001 -> CAPTURE code_f_d_ff=2, pc_ff=0x100,
//     code_e_m_ff=NO_E; flush 3 cycles; redirect 0x8000_0000 at N+5.
//   e_m code 4 pc 0x200 addr 0x1003 and f_d code 2 same cycle -> only e_m
//     presented (addr_ff=0x1003), f_d code_ff=NO_E, redirect to mtvec base.
//   mret with mepc 0x205 -> o_mret_e 1 cycle at N+1, redirect_pc=0x204.
//   Second exception during FLUSH -> ignored, single redirect pulse.
//   i_clk_en low 4 cycles mid-FLUSH -> redirect delayed exactly 4 cycles.
//   i_rst in FLUSH -> IDLE, o_flush=0, no redirect, codes=NO_E.

Source files
------------

// File: rtl/m_trap_sequencer.sv
// m_trap_sequencer
//   Drives the trap inputs of the machine-CSR file. It picks one raw event per
//   trap sequence, with this priority:
//     1. an execute/memory exception
//     2. a fetch/decode exception
//     3. an mret
//   The chosen event is presented to the CSR file as a one-cycle registered
//   write window. The sequencer then flushes the pipeline for FLUSH_CYCLES
//   cycles. Finally it redirects the PC, using the mtvec or mepc value that
//   the CSR file has just updated.
//
// Parameters
//   XLEN          width selector, data width W = 1 << (XLEN + 4)
//   FLUSH_CYCLES  number of cycles o_flush is held (1..15)
//   NO_E          4-bit "no exception" code
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_clk_en                  global clock enable; low freezes every register
//   i_exc_code_f_d / _pc_f_d  raw fetch/decode exception code and PC
//   i_exc_code_e_m / _pc_e_m  raw execute/memory exception code and PC
//   i_exc_addr_e_m            faulting data address (for mtval)
//   i_mret                    mret in the execute stage
//   i_mtvec, i_mepc           values read back from the CSR file
//   o_exception_*_ff          registered event fields to the CSR file
//   o_mret_e                  registered mret pulse to the CSR file
//   o_flush                   kills all in-flight pipeline stages
//   o_stall_fetch, o_busy     high whenever a trap sequence is in progress
//   o_redirect_valid/_pc      one-cycle PC redirect to the handler or return address
module m_trap_sequencer #(
  parameter int          XLEN         = 2,
  parameter int          FLUSH_CYCLES = 3,
  parameter logic [3:0]  NO_E         = 4'hF,
  localparam int         W            = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic [3:0]   i_exc_code_f_d,
  input  logic [W-1:0] i_exc_pc_f_d,
  input  logic [3:0]   i_exc_code_e_m,
  input  logic [W-1:0] i_exc_pc_e_m,
  input  logic [W-1:0] i_exc_addr_e_m,
  input  logic         i_mret,
  input  logic [W-1:0] i_mtvec,
  input  logic [W-1:0] i_mepc,
  output logic [3:0]   o_exception_code_f_d_ff,
  output logic [W-1:0] o_exception_pc_f_d_ff,
  output logic [3:0]   o_exception_code_e_m_ff,
  output logic [W-1:0] o_exception_pc_e_m_ff,
  output logic [W-1:0] o_exception_addr_e_m_ff,
  output logic         o_mret_e,
  output logic         o_flush,
  output logic         o_stall_fetch,
  output logic         o_redirect_valid,
  output logic [W-1:0] o_redirect_pc,
  output logic         o_busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, REDIRECT} state_t;

  state_t         state, state_n;
  logic [3:0]     flush_cnt, flush_cnt_n;
  logic           is_mret, is_mret_n;
  logic [3:0]     code_f_d, code_f_d_n;
  logic [W-1:0]   pc_f_d, pc_f_d_n;
  logic [3:0]     code_e_m, code_e_m_n;
  logic [W-1:0]   pc_e_m, pc_e_m_n;
  logic [W-1:0]   addr_e_m, addr_e_m_n;
  logic           mret_e, mret_e_n;

  logic exc_e_m, exc_f_d;

  assign exc_e_m = (i_exc_code_e_m != NO_E);
  assign exc_f_d = (i_exc_code_f_d != NO_E);

  // State and capture registers. i_clk_en low freezes the whole sequence,
  // including the flush counter, so a stalled core sees no time pass.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      is_mret   <= 1'b0;
      code_f_d  <= NO_E;
      pc_f_d    <= '0;
      code_e_m  <= NO_E;
      pc_e_m    <= '0;
      addr_e_m  <= '0;
      mret_e    <= 1'b0;
    end else if (i_clk_en) begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
      is_mret   <= is_mret_n;
      code_f_d  <= code_f_d_n;
      pc_f_d    <= pc_f_d_n;
      code_e_m  <= code_e_m_n;
      pc_e_m    <= pc_e_m_n;
      addr_e_m  <= addr_e_m_n;
      mret_e    <= mret_e_n;
    end
  end

  // Next-state logic. Only IDLE looks at new events. Anything that arrives
  // later belongs to the wrong path, which is about to be flushed.
  // The winner's fields are loaded together with a NO_E code for the loser.
  // As a result, the CSR file never sees two events in the same write window.
  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    is_mret_n   = is_mret;
    code_f_d_n  = code_f_d;
    pc_f_d_n    = pc_f_d;
    code_e_m_n  = code_e_m;
    pc_e_m_n    = pc_e_m;
    addr_e_m_n  = addr_e_m;
    mret_e_n    = mret_e;

    case (state)
      IDLE: begin
        if (exc_e_m) begin
          state_n    = CAPTURE;
          is_mret_n  = 1'b0;
          code_e_m_n = i_exc_code_e_m;
          pc_e_m_n   = i_exc_pc_e_m;
          addr_e_m_n = i_exc_addr_e_m;
          code_f_d_n = NO_E;
          pc_f_d_n   = '0;
          mret_e_n   = 1'b0;
        end else if (exc_f_d) begin
          state_n    = CAPTURE;
          is_mret_n  = 1'b0;
          code_f_d_n = i_exc_code_f_d;
          pc_f_d_n   = i_exc_pc_f_d;
          code_e_m_n = NO_E;
          pc_e_m_n   = '0;
          addr_e_m_n = '0;
          mret_e_n   = 1'b0;
        end else if (i_mret) begin
          state_n    = CAPTURE;
          is_mret_n  = 1'b1;
          code_f_d_n = NO_E;
          code_e_m_n = NO_E;
          mret_e_n   = 1'b1;
        end
      end
      CAPTURE: begin
        state_n     = FLUSH;
        code_f_d_n  = NO_E;
        code_e_m_n  = NO_E;
        mret_e_n    = 1'b0;
        flush_cnt_n = 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (flush_cnt == 4'd0) begin
          state_n = REDIRECT;
        end else begin
          flush_cnt_n = flush_cnt - 4'd1;
        end
      end
      REDIRECT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_exception_code_f_d_ff = code_f_d;
  assign o_exception_pc_f_d_ff   = pc_f_d;
  assign o_exception_code_e_m_ff = code_e_m;
  assign o_exception_pc_e_m_ff   = pc_e_m;
  assign o_exception_addr_e_m_ff = addr_e_m;
  assign o_mret_e                = mret_e;

  assign o_busy           = (state != IDLE);
  assign o_stall_fetch    = o_busy;
  assign o_flush          = (state == FLUSH);
  assign o_redirect_valid = (state == REDIRECT);

  // The target is read in REDIRECT so that it picks up the CSR values the
  // trap just wrote. Synchronous exceptions never vector, so the mtvec mode
  // bits are simply masked off.
  assign o_redirect_pc = (state != REDIRECT) ? '0 :
                         is_mret ? (i_mepc  & ~W'(1)) :
                                   (i_mtvec & ~W'(3));

endmodule
